pc_unit: RTL and testbench
==========================

PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 SHALL have parameter PC_W, default 16: PC and target width.
REQ-002 SHALL have parameter IMM_W, default 9: branch offset width, two's complement.
REQ-003 SHALL have parameter INC, default 2: sequential PC increment in bytes.
REQ-004 SHALL have parameter IMM_SHIFT, default 0: left shift applied to the sign-extended offset.
REQ-005 SHALL have parameter RESET_PC, default 0: PC value loaded at reset.
REQ-006 SHALL have port clk, input, 1: single clock, rising edge.
REQ-007 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-008 SHALL have port en, input, 1: advance enable; low = stall.
REQ-009 SHALL have port br_valid, input, 1: current instruction is a branch.
REQ-010 SHALL have port br_reg, input, 1: 1 = register-target branch (BR), 0 = PC-relative branch (B).
REQ-011 SHALL have port cond, input, 3: condition code.
REQ-012 SHALL have port imm, input, IMM_W: PC-relative offset.
REQ-013 SHALL have port flags, input, 3: {N,V,Z} as [2]=N, [1]=V, [0]=Z.
REQ-014 SHALL have port reg_target, input, PC_W: target for BR.
REQ-015 SHALL have port halt, input, 1: current instruction is HLT.
REQ-016 SHALL have port pc, output, PC_W: registered current PC.
REQ-017 SHALL have port pc_seq, output, PC_W: combinational pc+INC (PCS link value).
REQ-018 SHALL have port taken, output, 1: combinational branch-taken indication for the current pc.
REQ-019 SHALL have port flush, output, 1: registered; high for exactly one cycle after a taken branch commits.
REQ-020 SHALL have port halted, output, 1: registered; high while in state HALTED.

Function
REQ-021 SHALL evaluate cond as follows: 000 Z=0; 001 Z=1; 010 Z=0&N=0; 011 N=1; 100 Z=1|(Z=0&N=0); 101 N=1|Z=1; 110 V=1; 111 always.
REQ-022 SHALL drive taken = br_valid & cond_true & state==RUN.
REQ-023 SHALL compute pc_seq = pc + INC, modulo 2^PC_W.
REQ-024 SHALL compute the B target = pc_seq + (sext(imm) << IMM_SHIFT), modulo 2^PC_W, with no overflow flag.
REQ-025 SHALL use reg_target unmodified as the BR target.
REQ-026 SHALL update pc on each clock edge with en=1 in state RUN: taken ? target : pc_seq.
REQ-027 SHALL hold pc, keep flush low and leave the state unchanged on any edge with en=0.
REQ-028 SHALL implement the FSM states RUN and HALTED.
REQ-029 SHALL, in RUN with en=1 and halt=1, hold pc (not advance) and move to HALTED; halt SHALL take priority over br_valid.
REQ-030 SHALL make HALTED terminal until reset: pc held, taken=0, flush=0, all inputs ignored.
REQ-031 SHALL set flush on the edge after a committed taken branch (en=1, RUN, taken=1), and clear it on the next edge.
REQ-032 SHALL let a taken branch whose target equals pc_seq still assert flush.
REQ-033 SHALL produce wrap-around results for pc at 2^PC_W-INC plus INC, and for negative offsets below 0, with no saturation.

Reset
REQ-034 SHALL, on rst_n low, asynchronously force pc=RESET_PC, flush=0, halted=0 and state=RUN, including mid-branch or while HALTED.
REQ-035 SHALL resume normal update on the first rising clk edge after rst_n deasserts.

Structure
REQ-036 SHALL take the condition-code constants (NE, EQ, GT, LT, GE, LE, OV, UN) and the FSM state encoding from shared package cpu_pkg.
REQ-037 SHALL instantiate one sub-module, branch_cond, which is combinational and maps (cond, flags) to cond_true.
REQ-038 SHALL build the adders with the existing addsub_16bit only when PC_W=16, and use generic addition otherwise.

Verification
REQ-039 SHALL verify sequential flow: reset, then 3 cycles with en=1, br_valid=0 -> pc = 0, 2, 4, 6.
REQ-040 SHALL verify the NE branch: pc=0x0010, br_valid=1, cond=000, flags=000, imm=9'h001 -> next pc=0x0013 and flush=1 for one cycle; with flags=001 -> next pc=0x0012 and flush=0.
REQ-041 SHALL verify a negative offset with wrap: pc=0x0000, cond=111, imm=9'h1F0 -> next pc=0xFFF2.
REQ-042 SHALL verify BR plus stall: br_reg=1, reg_target=0x1234, cond=111, en=0 for 2 cycles then en=1 -> pc held for 2 cycles, then pc=0x1234.
REQ-043 SHALL verify halt priority: halt=1 and br_valid=1 with cond=111 at pc=0x0020 -> pc stays 0x0020, halted=1, and no further change over 5 cycles.
REQ-044 SHALL verify asynchronous reset: assert rst_n low between edges while HALTED with pc=0x0020 -> pc=0x0000 and halted=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: branch condition codes and the PC sequencer state encoding.
package cpu_pkg;

    localparam int unsigned COND_W = 3;

    localparam logic [COND_W-1:0] COND_NE = 3'b000;
    localparam logic [COND_W-1:0] COND_EQ = 3'b001;
    localparam logic [COND_W-1:0] COND_GT = 3'b010;
    localparam logic [COND_W-1:0] COND_LT = 3'b011;
    localparam logic [COND_W-1:0] COND_GE = 3'b100;
    localparam logic [COND_W-1:0] COND_LE = 3'b101;
    localparam logic [COND_W-1:0] COND_OV = 3'b110;
    localparam logic [COND_W-1:0] COND_UN = 3'b111;

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } pc_state_e;

endpackage

// File: rtl/addsub_16bit.sv
// 16-bit adder/subtractor used for the PC datapath when the PC is 16 bits wide.
module addsub_16bit (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        sub,
    output logic [15:0] sum
);

    logic [15:0] w_b_op;

    assign w_b_op = sub ? ~b : b;
    assign sum    = a + w_b_op + 16'(sub);

endmodule

// File: rtl/branch_cond.sv
// Combinational branch condition evaluator: maps (cond, {N,V,Z}) to cond_true.
module branch_cond
    import cpu_pkg::*;
(
    input  logic [COND_W-1:0] cond,
    input  logic [2:0]        flags,
    output logic              cond_true
);

    logic w_n;
    logic w_v;
    logic w_z;

    assign w_n = flags[2];
    assign w_v = flags[1];
    assign w_z = flags[0];

    always_comb begin
        cond_true = 1'b0;
        case (cond)
            COND_NE: cond_true = !w_z;
            COND_EQ: cond_true = w_z;
            COND_GT: cond_true = !w_z && !w_n;
            COND_LT: cond_true = w_n;
            COND_GE: cond_true = w_z || (!w_z && !w_n);
            COND_LE: cond_true = w_n || w_z;
            COND_OV: cond_true = w_v;
            COND_UN: cond_true = 1'b1;
            default: cond_true = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_unit.sv
// Program counter sequencer: sequential advance, PC-relative and register branches,
// stall, and a terminal HALTED state left only through reset.
module pc_unit
    import cpu_pkg::*;
#(
    parameter int unsigned PC_W      = 16,
    parameter int unsigned IMM_W     = 9,
    parameter int unsigned INC       = 2,
    parameter int unsigned IMM_SHIFT = 0,
    parameter int unsigned RESET_PC  = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              br_valid,
    input  logic              br_reg,
    input  logic [COND_W-1:0] cond,
    input  logic [IMM_W-1:0]  imm,
    input  logic [2:0]        flags,
    input  logic [PC_W-1:0]   reg_target,
    input  logic              halt,
    output logic [PC_W-1:0]   pc,
    output logic [PC_W-1:0]   pc_seq,
    output logic              taken,
    output logic              flush,
    output logic              halted
);

    pc_state_e       r_state;
    pc_state_e       w_state_nxt;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_pc_nxt;
    logic [PC_W-1:0] w_off;
    logic [PC_W-1:0] w_b_target;
    logic [PC_W-1:0] w_target;
    logic            r_flush;
    logic            w_flush_nxt;
    logic            r_halted;
    logic            w_cond_true;
    logic            w_commit;

    branch_cond u_branch_cond (
        .cond      (cond),
        .flags     (flags),
        .cond_true (w_cond_true)
    );

    // Sign-extend the offset to PC width before scaling; wrap is intentional.
    assign w_off = PC_W'($signed(imm)) << IMM_SHIFT;

    generate
        if (PC_W == 16) begin : g_addsub
            addsub_16bit u_inc (
                .a   (r_pc),
                .b   (16'(INC)),
                .sub (1'b0),
                .sum (pc_seq)
            );
            addsub_16bit u_tgt (
                .a   (pc_seq),
                .b   (w_off),
                .sub (1'b0),
                .sum (w_b_target)
            );
        end else begin : g_generic
            assign pc_seq     = r_pc + PC_W'(INC);
            assign w_b_target = pc_seq + w_off;
        end
    endgenerate

    assign w_target = br_reg ? reg_target : w_b_target;
    assign taken    = br_valid && w_cond_true && (r_state == ST_RUN);
    assign w_commit = en && (r_state == ST_RUN);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        if (w_commit && halt) begin
            w_state_nxt = ST_HALTED;
        end
    end

    // Output logic: halt wins over any branch in the same cycle
    always_comb begin
        w_pc_nxt    = r_pc;
        w_flush_nxt = 1'b0;
        if (w_commit && !halt) begin
            w_pc_nxt    = taken ? w_target : pc_seq;
            w_flush_nxt = taken;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc     <= PC_W'(RESET_PC);
            r_flush  <= 1'b0;
            r_halted <= 1'b0;
        end else begin
            r_pc     <= w_pc_nxt;
            r_flush  <= w_flush_nxt;
            r_halted <= (w_state_nxt == ST_HALTED);
        end
    end

    assign pc     = r_pc;
    assign flush  = r_flush;
    assign halted = r_halted;

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: a reference model pushes expected post-edge state
// into a scoreboard queue that is popped and compared after each rising edge.
module tb_pc_unit;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        br_valid;
    logic        br_reg;
    logic [2:0]  cond;
    logic [8:0]  imm;
    logic [2:0]  flags;
    logic [15:0] reg_target;
    logic        halt;
    logic [15:0] pc;
    logic [15:0] pc_seq;
    logic        taken;
    logic        flush;
    logic        halted;

    typedef struct {
        logic [15:0] pc;
        logic        flush;
        logic        halted;
    } exp_t;

    exp_t        sb[$];
    int          n_checks;
    int          n_errors;
    logic [15:0] m_pc;
    logic        m_flush;
    logic        m_halted;

    pc_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .br_valid   (br_valid),
        .br_reg     (br_reg),
        .cond       (cond),
        .imm        (imm),
        .flags      (flags),
        .reg_target (reg_target),
        .halt       (halt),
        .pc         (pc),
        .pc_seq     (pc_seq),
        .taken      (taken),
        .flush      (flush),
        .halted     (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference condition table written from the {N,V,Z} definitions
    function automatic logic m_cond(input logic [2:0] c, input logic [2:0] f);
        logic n, v, z;
        n = f[2];
        v = f[1];
        z = f[0];
        case (c)
            3'd0: return z == 1'b0;
            3'd1: return z == 1'b1;
            3'd2: return (z == 1'b0) && (n == 1'b0);
            3'd3: return n == 1'b1;
            3'd4: return (z == 1'b1) || ((z == 1'b0) && (n == 1'b0));
            3'd5: return (n == 1'b1) || (z == 1'b1);
            3'd6: return v == 1'b1;
            default: return 1'b1;
        endcase
    endfunction

    // One clock: drive, check combinational outputs, push expectation, then compare after the edge.
    task automatic cycle(input logic i_en, input logic i_bv, input logic i_brr,
                         input logic [2:0] i_cond, input logic [8:0] i_imm,
                         input logic [2:0] i_flags, input logic [15:0] i_rt, input logic i_halt);
        logic        exp_taken;
        logic [15:0] seq;
        logic [15:0] tgt;
        exp_t        e;
        exp_t        got_e;
        en         = i_en;
        br_valid   = i_bv;
        br_reg     = i_brr;
        cond       = i_cond;
        imm        = i_imm;
        flags      = i_flags;
        reg_target = i_rt;
        halt       = i_halt;
        #1;
        exp_taken = i_bv && m_cond(i_cond, i_flags) && !m_halted;
        seq       = m_pc + 16'd2;
        tgt       = i_brr ? i_rt : seq + {{7{i_imm[8]}}, i_imm};
        check("taken", 32'(taken), 32'(exp_taken));
        check("pc_seq", 32'(pc_seq), 32'(seq));
        if (!m_halted && i_en) begin
            if (i_halt) begin
                m_halted = 1'b1;
                m_flush  = 1'b0;
            end else begin
                m_pc    = exp_taken ? tgt : seq;
                m_flush = exp_taken;
            end
        end else begin
            m_flush = 1'b0;
        end
        e.pc     = m_pc;
        e.flush  = m_flush;
        e.halted = m_halted;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check("sb_empty", 32'(1), 32'(0));
        end else begin
            got_e = sb.pop_front();
            check("pc", 32'(pc), 32'(got_e.pc));
            check("flush", 32'(flush), 32'(got_e.flush));
            check("halted", 32'(halted), 32'(got_e.halted));
        end
    endtask

    task automatic seq_step();
        cycle(1'b1, 1'b0, 1'b0, 3'd0, 9'd0, 3'd0, 16'h0000, 1'b0);
    endtask

    task automatic br_to(input logic [15:0] t);
        cycle(1'b1, 1'b1, 1'b1, 3'd7, 9'd0, 3'd0, t, 1'b0);
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        rst_n      = 1'b0;
        en         = 1'b0;
        br_valid   = 1'b0;
        br_reg     = 1'b0;
        cond       = 3'd0;
        imm        = 9'd0;
        flags      = 3'd0;
        reg_target = 16'h0000;
        halt       = 1'b0;
        m_pc       = 16'h0000;
        m_flush    = 1'b0;
        m_halted   = 1'b0;

        #3;
        check("rst_pc", 32'(pc), 32'h0);
        check("rst_flush", 32'(flush), 32'h0);
        check("rst_halted", 32'(halted), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Sequential flow 0 -> 2 -> 4 -> 6
        repeat (3) seq_step();
        check("seq_pc6", 32'(pc), 32'h6);

        // NE taken: 0x10 + 2 + 1 = 0x13, flush for exactly one cycle
        br_to(16'h000E);
        seq_step();
        cycle(1'b1, 1'b1, 1'b0, 3'd0, 9'h001, 3'b000, 16'h0, 1'b0);
        check("ne_taken_pc", 32'(pc), 32'h13);
        check("ne_taken_flush", 32'(flush), 32'h1);
        seq_step();
        check("flush_one_cycle", 32'(flush), 32'h0);

        // NE not taken with Z=1
        br_to(16'h000E);
        seq_step();
        cycle(1'b1, 1'b1, 1'b0, 3'd0, 9'h001, 3'b001, 16'h0, 1'b0);
        check("ne_nt_pc", 32'(pc), 32'h12);
        check("ne_nt_flush", 32'(flush), 32'h0);

        // Sequential wrap 0xFFFE -> 0x0000, then negative offset wrap to 0xFFF2
        br_to(16'hFFFE);
        seq_step();
        check("wrap_pc", 32'(pc), 32'h0);
        cycle(1'b1, 1'b1, 1'b0, 3'd7, 9'h1F0, 3'd0, 16'h0, 1'b0);
        check("neg_wrap_pc", 32'(pc), 32'hFFF2);

        // Taken branch whose target equals pc_seq still flushes
        seq_step();
        cycle(1'b1, 1'b1, 1'b0, 3'd7, 9'h000, 3'd0, 16'h0, 1'b0);
        check("tgt_eq_seq_flush", 32'(flush), 32'h1);

        // BR with two stall cycles
        cycle(1'b0, 1'b1, 1'b1, 3'd7, 9'd0, 3'd0, 16'h1234, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 3'd7, 9'd0, 3'd0, 16'h1234, 1'b0);
        check("stall_flush_low", 32'(flush), 32'h0);
        cycle(1'b1, 1'b1, 1'b1, 3'd7, 9'd0, 3'd0, 16'h1234, 1'b0);
        check("br_pc", 32'(pc), 32'h1234);

        // Condition sweep against the model with occasional stalls
        for (int c = 0; c < 8; c++) begin
            for (int f = 0; f < 8; f++) begin
                cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
                      1'($urandom_range(0, 1)), 3'(c), 9'($urandom), 3'(f),
                      16'($urandom), 1'b0);
            end
        end

        // Halt takes priority over a taken branch; HALTED ignores all inputs
        br_to(16'h001E);
        seq_step();
        cycle(1'b1, 1'b1, 1'b0, 3'd7, 9'h010, 3'd0, 16'h0, 1'b1);
        check("halt_pc", 32'(pc), 32'h20);
        check("halt_state", 32'(halted), 32'h1);
        for (int i = 0; i < 5; i++) begin
            cycle(1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1)), 3'd7,
                  9'($urandom), 3'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
        end
        check("halted_hold_pc", 32'(pc), 32'h20);

        // Asynchronous reset between edges while HALTED
        en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_pc", 32'(pc), 32'h0);
        check("async_rst_halted", 32'(halted), 32'h0);
        check("async_rst_flush", 32'(flush), 32'h0);
        m_pc     = 16'h0000;
        m_flush  = 1'b0;
        m_halted = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        seq_step();
        check("post_rst_pc", 32'(pc), 32'h2);

        check("sb_drained", 32'(sb.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
